// File: rtl/stream_resp_pkg.sv
// stream_resp_pkg: shared types for the stream sink responder.
//   err_code_t  - first protocol violation seen by the responder
//   BEAT_CNT_W  - width of the accepted-beat counter
package stream_resp_pkg;
  localparam int BEAT_CNT_W = 32;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_VALID_DROP,
    ERR_DATA_CHANGE
  } err_code_t;
endpackage

// File: rtl/stream_resp_fifo.sv
// stream_resp_fifo: capture FIFO for accepted beats.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   push, data   write data at tail (ignored when full)
//   pop          consume head (ignored when empty)
//   full, empty  occupancy flags
//   count        number of stored entries, 0..DEPTH
//   head         entry at head; 0 when empty
module stream_resp_fifo #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 4,
  localparam int AW     = $clog2(DEPTH),
  localparam int CW     = AW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [CW-1:0]     count,
  output logic [DATA_W-1:0] head
);
  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic [AW-1:0]                wr_ptr, rd_ptr;
  logic                         do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // Storage is not reset, so the head is masked while empty.
  assign head    = empty ? '0 : mem[rd_ptr];

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= data;
  end
endmodule

// File: rtl/stream_sink_responder.sv
// stream_sink_responder: bindable accepting end of a valid/ready stream.
// Drives ready_o with a periodic back-pressure pattern, captures accepted
// beats in a FIFO, counts them, and latches the first producer violation.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   valid_i, data_i         producer stream
//   ready_o                 registered responder ready
//   out_valid_o/out_data_o  FIFO non-empty / head
//   out_pop_i               consume head (ignored when empty)
//   beat_cnt_o              accepted beats, wraps
//   err_o, err_code_o       sticky error flag and first error code
// Build option: define STREAM_SINK_RESPONDER_TRACE_EN to print each
// accepted beat and the first latched error with the instance path.
module stream_sink_responder
  import stream_resp_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int DEPTH        = 4,
  parameter int STALL_PERIOD = 4,
  parameter int STALL_LEN    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_i,
  input  logic [DATA_W-1:0]     data_i,
  output logic                  ready_o,
  output logic                  out_valid_o,
  output logic [DATA_W-1:0]     out_data_o,
  input  logic                  out_pop_i,
  output logic [BEAT_CNT_W-1:0] beat_cnt_o,
  output logic                  err_o,
  output err_code_t             err_code_o
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
  localparam logic [PW-1:0] PHASE_MAX = PW'(STALL_PERIOD - 1);
  // One extra bit so STALL_LEN=0 (limit == STALL_PERIOD) still fits.
  localparam logic [PW:0]   READY_LIM = (PW+1)'(STALL_PERIOD - STALL_LEN);

  logic [PW-1:0]     phase, phase_next;
  logic              push, pop, full, empty;
  logic [CW-1:0]     count, count_next;
  logic              live, prev_valid, prev_ready, stalled;
  logic [DATA_W-1:0] prev_data;
  logic              err_drop, err_chg;

  stream_resp_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .data  (data_i),
    .pop   (pop),
    .full  (full),
    .empty (empty),
    .count (count),
    .head  (out_data_o)
  );

  assign out_valid_o = !empty;

  always_comb begin
    phase_next = (phase == PHASE_MAX) ? '0 : phase + 1'b1;
    push       = valid_i && ready_o;
    pop        = out_pop_i && !empty;
    count_next = count + CW'(push) - CW'(pop);
    stalled    = prev_valid && !prev_ready;
    err_drop   = stalled && !valid_i;
    err_chg    = stalled && valid_i && (data_i != prev_data);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase      <= '0;
      ready_o    <= 1'b0;
      beat_cnt_o <= '0;
    end else begin
      phase      <= phase_next;
      ready_o    <= ({1'b0, phase_next} < READY_LIM) && (count_next < CW'(DEPTH));
      if (push) beat_cnt_o <= beat_cnt_o + 1'b1;
    end
  end

  // The cycle between reset release and the first edge has ready_o low
  // through no choice of the pattern; 'live' keeps a valid held across
  // reset from being treated as a stalled beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live       <= 1'b0;
      prev_valid <= 1'b0;
      prev_ready <= 1'b0;
      prev_data  <= '0;
    end else begin
      live       <= 1'b1;
      prev_valid <= valid_i && live;
      prev_ready <= ready_o;
      prev_data  <= data_i;
    end
  end

  // First error wins; drop and change are mutually exclusive on valid_i.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_o      <= 1'b0;
      err_code_o <= ERR_NONE;
    end else if (!err_o && (err_drop || err_chg)) begin
      err_o      <= 1'b1;
      err_code_o <= err_drop ? ERR_VALID_DROP : ERR_DATA_CHANGE;
    end
  end

`ifdef STREAM_SINK_RESPONDER_TRACE_EN
  always @(posedge clk) begin
    if (rst_n) begin
      if (push) $display("%m: beat %0d data=0x%h", beat_cnt_o, data_i);
      if (!err_o && (err_drop || err_chg))
        $display("%m: ERROR %s", err_drop ? "ERR_VALID_DROP" : "ERR_DATA_CHANGE");
    end
  end
`else
  // Trace disabled: no display code in this build.
`endif
endmodule
